// File: rtl/bky_autoload_ctrl.sv
// bky_autoload_ctrl: Buckeye amplifier autoload sequencer.
// Reads the stored shift pattern from config RAM (word 0 first, MSB first) and
// streams it serially into the NAMPS-amplifier shift chain.
// Optional feature macro: BKY_AL_READBACK_EN (two back-to-back passes; the
// second pass compares the chain return against the pattern and flags ERR).
// Ports:
//   clk1mhz_i      1 MHz clock (also gates the amplifier shift clock downstream)
//   rst_n_i        asynchronous active-low reset
//   start_i        single-cycle load request, honoured only when idle
//   abort_i        terminate a running load (SETUP/SHIFT only)
//   rd_addr_o      config RAM word address
//   rd_data_i      config RAM data, valid one cycle after rd_addr_o
//   al_rtn_i       chain return, used only for readback
//   al_bky_ena_o   autoload owns the chain
//   al_shck_ena_o  enables shift clock pulses
//   al_sdata_o     serial data into amp 1
//   busy_o         load in progress
//   done_o         one-cycle completion/abort pulse
//   err_o          sticky readback mismatch flag
module bky_autoload_ctrl #(
    parameter int unsigned NAMPS  = 6,
    parameter int unsigned BPA    = 48,
    parameter int unsigned WORD_W = 16,
    parameter int unsigned AW     = 5,
    parameter int unsigned GUARD  = 2
) (
    input  logic              clk1mhz_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic              abort_i,
    output logic [AW-1:0]     rd_addr_o,
    input  logic [WORD_W-1:0] rd_data_i,
    input  logic              al_rtn_i,
    output logic              al_bky_ena_o,
    output logic              al_shck_ena_o,
    output logic              al_sdata_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int unsigned NBITS  = NAMPS * BPA;
    localparam int unsigned NWORDS = NBITS / WORD_W;
    localparam int unsigned CW     = $clog2(NBITS + 1);
    localparam int unsigned WBW    = $clog2(WORD_W);
    localparam int unsigned GW     = (GUARD > 1) ? $clog2(GUARD) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_TRAIL
    } state_e;

    state_e            state_q, state_d;
    logic [GW-1:0]     gcnt_q, gcnt_d;
    logic [CW-1:0]     bcnt_q, bcnt_d;
    logic [WBW-1:0]    wbit_q, wbit_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [AW-1:0]     rd_addr_q, rd_addr_d;
    logic              bky_q, bky_d;
    logic              shck_q, shck_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [AW-1:0]     addr_next;
    logic              last_pass;
`ifdef BKY_AL_READBACK_EN
    logic              pass_q, pass_d;
`else
    logic              unused_rtn;
    assign unused_rtn = al_rtn_i;
`endif

    // Prefetch address for the word after the current one.
    always_comb begin
        addr_next = (rd_addr_q == AW'(NWORDS - 1)) ? rd_addr_q : rd_addr_q + AW'(1);
`ifdef BKY_AL_READBACK_EN
        // Last word of pass 1 wraps the prefetch back to word 0 for pass 2.
        if (!pass_q && rd_addr_q == AW'(NWORDS - 1)) begin
            addr_next = '0;
        end
        last_pass = pass_q;
`else
        last_pass = 1'b1;
`endif
    end

    // Next-state and output logic.
    always_comb begin
        state_d   = state_q;
        gcnt_d    = gcnt_q;
        bcnt_d    = bcnt_q;
        wbit_d    = wbit_q;
        shreg_d   = shreg_q;
        rd_addr_d = rd_addr_q;
        bky_d     = bky_q;
        shck_d    = shck_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
`ifdef BKY_AL_READBACK_EN
        pass_d    = pass_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                // Parking the address at 0 keeps word 0 ready for the next load.
                rd_addr_d = '0;
                if (start_i) begin
                    state_d = ST_SETUP;
                    gcnt_d  = '0;
                    busy_d  = 1'b1;
                    bky_d   = 1'b1;
                    err_d   = 1'b0;
                end
            end
            ST_SETUP: begin
                if (abort_i) begin
                    state_d = ST_TRAIL;
                    gcnt_d  = '0;
                end else if (gcnt_q == GW'(GUARD - 1)) begin
                    state_d   = ST_SHIFT;
                    shck_d    = 1'b1;
                    shreg_d   = rd_data_i;
                    rd_addr_d = addr_next;
                    bcnt_d    = '0;
                    wbit_d    = '0;
`ifdef BKY_AL_READBACK_EN
                    pass_d    = 1'b0;
`endif
                end else begin
                    gcnt_d = gcnt_q + GW'(1);
                end
            end
            ST_SHIFT: begin
                if (abort_i || (bcnt_q == CW'(NBITS - 1) && last_pass)) begin
                    // Shift clock stops at once; data line returns low.
                    state_d = ST_TRAIL;
                    shck_d  = 1'b0;
                    shreg_d = '0;
                    gcnt_d  = '0;
                end else begin
                    bcnt_d = (bcnt_q == CW'(NBITS - 1)) ? '0 : bcnt_q + CW'(1);
                    if (wbit_q == WBW'(WORD_W - 1)) begin
                        shreg_d   = rd_data_i;
                        wbit_d    = '0;
                        rd_addr_d = addr_next;
                    end else begin
                        shreg_d = {shreg_q[WORD_W-2:0], 1'b0};
                        wbit_d  = wbit_q + WBW'(1);
                    end
`ifdef BKY_AL_READBACK_EN
                    if (bcnt_q == CW'(NBITS - 1)) begin
                        pass_d = 1'b1;
                    end
`endif
                end
            end
            ST_TRAIL: begin
                if (gcnt_q == GW'(GUARD - 1)) begin
                    state_d   = ST_IDLE;
                    bky_d     = 1'b0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    rd_addr_d = '0;
                end else begin
                    gcnt_d = gcnt_q + GW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef BKY_AL_READBACK_EN
        // The chain return is sampled before the amps shift, so it must equal the
        // pattern bit about to be driven in this pass-2 cycle.
        if (state_d == ST_SHIFT && pass_d && (al_rtn_i != shreg_d[WORD_W-1])) begin
            err_d = 1'b1;
        end
`endif
    end

    // State and output registers.
    always_ff @(posedge clk1mhz_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            gcnt_q    <= '0;
            bcnt_q    <= '0;
            wbit_q    <= '0;
            shreg_q   <= '0;
            rd_addr_q <= '0;
            bky_q     <= 1'b0;
            shck_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef BKY_AL_READBACK_EN
            pass_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            gcnt_q    <= gcnt_d;
            bcnt_q    <= bcnt_d;
            wbit_q    <= wbit_d;
            shreg_q   <= shreg_d;
            rd_addr_q <= rd_addr_d;
            bky_q     <= bky_d;
            shck_q    <= shck_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
`ifdef BKY_AL_READBACK_EN
            pass_q    <= pass_d;
`endif
        end
    end

    assign rd_addr_o     = rd_addr_q;
    assign al_bky_ena_o  = bky_q;
    assign al_shck_ena_o = shck_q;
    assign al_sdata_o    = shreg_q[WORD_W-1];
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_bky_autoload_ctrl.sv
// Testbench for bky_autoload_ctrl: RAM model, chain model and a serial-bit
// scoreboard; expected stream bits are queued at START and popped on every
// shift-clock cycle. Build with BKY_AL_READBACK_EN to exercise readback.
module tb_bky_autoload_ctrl;

    localparam int unsigned NAMPS  = 6;
    localparam int unsigned BPA    = 48;
    localparam int unsigned WORD_W = 16;
    localparam int unsigned AW     = 5;
    localparam int unsigned GUARD  = 2;
    localparam int unsigned NBITS  = NAMPS * BPA;
    localparam int unsigned NWORDS = NBITS / WORD_W;
`ifdef BKY_AL_READBACK_EN
    localparam int unsigned NPASS  = 2;
`else
    localparam int unsigned NPASS  = 1;
`endif
    localparam int TMO = int'(NPASS * NBITS) + 100;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [AW-1:0]     rd_addr;
    logic [WORD_W-1:0] rd_data = '0;
    logic              al_rtn;
    logic              bky, shck, sdata, busy, done, err;

    logic [WORD_W-1:0] mem [2**AW];
    logic [NBITS-1:0]  chain  = '0;
    logic              stuck7 = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    int cyc = 0;
    int bits_seen, done_cnt, start_cyc, first_shck_cyc, last_shck_cyc, done_cyc, max_addr;
    bit exp_q[$];
    bit exp_b;

    bky_autoload_ctrl #(
        .NAMPS (NAMPS),
        .BPA   (BPA),
        .WORD_W(WORD_W),
        .AW    (AW),
        .GUARD (GUARD)
    ) dut (
        .clk1mhz_i    (clk),
        .rst_n_i      (rst_n),
        .start_i      (start),
        .abort_i      (abort),
        .rd_addr_o    (rd_addr),
        .rd_data_i    (rd_data),
        .al_rtn_i     (al_rtn),
        .al_bky_ena_o (bky),
        .al_shck_ena_o(shck),
        .al_sdata_o   (sdata),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    // Synchronous-read config RAM: data one cycle after the address.
    always @(posedge clk) rd_data <= mem[rd_addr];

    // Amplifier chain shifts on the falling edge of the gated clock.
    assign al_rtn = chain[NBITS-1];
    always @(negedge clk) begin
        if (shck) begin
            chain = {chain[NBITS-2:0], sdata};
            if (stuck7) chain[7] = 1'b1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit pat_bit(input int j);
        logic [WORD_W-1:0] w;
        int k;
        w = WORD_W'(32'hA5A5 ^ (j / int'(WORD_W)));
        k = int'(WORD_W) - 1 - (j % int'(WORD_W));
        return w[k];
    endfunction

    // Monitor: pops the scoreboard on every shift cycle and records timing.
    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (start && !busy) start_cyc = cyc;
            if (shck) begin
                if (bits_seen == 0) first_shck_cyc = cyc;
                last_shck_cyc = cyc;
                check_val("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    exp_b = exp_q.pop_front();
                    check_val($sformatf("sdata_bit%0d", bits_seen), 32'(sdata), 32'(exp_b));
                end
                bits_seen++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (int'(rd_addr) > max_addr) max_addr = int'(rd_addr);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        bits_seen = 0; done_cnt = 0; max_addr = 0;
        start_cyc = -1000; first_shck_cyc = -1000; last_shck_cyc = -1000; done_cyc = -1000;
        exp_q.delete();
    endtask

    task automatic push_pattern();
        for (int p = 0; p < int'(NPASS); p++)
            for (int j = 0; j < int'(NBITS); j++) exp_q.push_back(pat_bit(j));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done_cnt == 0 && n < TMO) begin
            tick();
            n++;
        end
        check_val({tag, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
        tick();
        tick();
    endtask

    task automatic wait_bits(input int nb, input string tag);
        int n;
        n = 0;
        while (bits_seen < nb && n < TMO) begin
            tick();
            n++;
        end
        check_val({tag, "_bits_reached"}, 32'(bits_seen), 32'(nb));
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
        check_val({tag, "_bky"},     32'(bky),     32'd0);
        check_val({tag, "_shck"},    32'(shck),    32'd0);
        check_val({tag, "_sdata"},   32'(sdata),   32'd0);
        check_val({tag, "_busy"},    32'(busy),    32'd0);
        check_val({tag, "_done"},    32'(done),    32'd0);
        check_val({tag, "_err"},     32'(err),     32'd0);
    endtask

    // Full clean load: stream, latency, DONE pulse, address range.
    task automatic full_load(input string tag, input bit exp_err);
        clear_stats();
        push_pattern();
        pulse_start();
        check_val({tag, "_busy_setup"}, 32'(busy), 32'd1);
        check_val({tag, "_bky_setup"},  32'(bky),  32'd1);
        check_val({tag, "_shck_setup"}, 32'(shck), 32'd0);
        wait_done(tag);
        check_val({tag, "_bits"},        32'(bits_seen), 32'(NPASS * NBITS));
        check_val({tag, "_sb_drained"},  32'(exp_q.size()), 32'd0);
        check_val({tag, "_lat_shck"},    32'(first_shck_cyc - start_cyc), 32'(GUARD + 1));
        // DONE occupies cycle 2*GUARD+NBITS*NPASS+1 after the START cycle, i.e. the
        // (2*GUARD+NBITS*NPASS+2)-th cycle counting the START cycle as the first.
        check_val({tag, "_lat_done"},    32'(done_cyc - start_cyc), 32'(2 * GUARD + NPASS * NBITS + 1));
        check_val({tag, "_trail"},       32'(done_cyc - last_shck_cyc), 32'(GUARD + 1));
        check_val({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
        check_val({tag, "_addr_max_ok"}, 32'(max_addr <= int'(NWORDS) - 1), 32'd1);
        check_val({tag, "_busy_end"},    32'(busy), 32'd0);
        check_val({tag, "_bky_end"},     32'(bky),  32'd0);
        check_val({tag, "_err"},         32'(err),  32'(exp_err));
    endtask

    initial begin
        for (int n = 0; n < 2**AW; n++)
            mem[n] = (n < int'(NWORDS)) ? WORD_W'(32'hA5A5 ^ n) : WORD_W'(32'h0F0F ^ n);
        clear_stats();

        // Reset state.
        tick(); tick(); tick();
        check_idle_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Clean load; every bit checked incl. word boundaries 15/16 and 271/272.
        full_load("load1", 1'b0);

        // START while busy, mid-shift, is ignored.
        clear_stats();
        push_pattern();
        pulse_start();
        wait_bits(150, "busy_start");
        pulse_start();
        wait_done("busy_start");
        check_val("busy_start_bits",  32'(bits_seen), 32'(NPASS * NBITS));
        check_val("busy_start_dones", 32'(done_cnt),  32'd1);

        // ABORT on shift bit 100.
        clear_stats();
        push_pattern();
        pulse_start();
        wait_bits(100, "abort");
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_val("abort_shck_drop", 32'(shck), 32'd0);
        check_val("abort_bky_held",  32'(bky),  32'd1);
        check_val("abort_busy_held", 32'(busy), 32'd1);
        wait_done("abort");
        check_val("abort_bits",  32'(bits_seen), 32'd101);
        check_val("abort_trail", 32'(done_cyc - last_shck_cyc), 32'(GUARD + 1));
        check_val("abort_busy",  32'(busy), 32'd0);
        check_val("abort_dones", 32'(done_cnt), 32'd1);

        // Reset asserted on shift bit 50: outputs clear asynchronously.
        clear_stats();
        push_pattern();
        pulse_start();
        wait_bits(50, "rst_mid");
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("rst_mid");
        tick(); tick();
        rst_n = 1'b1;
        tick();
        full_load("after_rst", 1'b0);

`ifdef BKY_AL_READBACK_EN
        // Chain bit 7 stuck at 1 corrupts zeros in the pattern.
        stuck7 = 1'b1;
        full_load("stuck7", 1'b1);
        stuck7 = 1'b0;
        full_load("rb_clean", 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
